// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg: shared state encoding, default sizes and clog2 helper for the write-port arbiter
package regfile_wr_arbiter_pkg;
    typedef enum logic {INIT = 1'b0, ARB = 1'b1} state_t;
    localparam int DEF_NREQ = 4;
    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/regfile_wr_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick; first set bit of req searching from ptr upward, wrapping.
//   req   : request vector
//   ptr   : highest-priority index
//   grant : one-hot grant, zero when no request
//   idx   : index of the granted bit (0 when no request)
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);
    int c;
    // Walk from the lowest priority back to ptr so the last hit is the winner.
    always_comb begin
        grant = '0;
        idx = '0;
        c = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % NREQ;
            if (req[c]) begin
                grant = '0;
                grant[c] = 1'b1;
                idx = IW'(c);
            end
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: owns the register-file write port; zero sweep after reset/clear, then round-robin arbitration.
//   clk, reset (async active-low), clear (re-initialisation pulse)
//   req_valid/req_ready/req_addr/req_data : per-requester handshake, packed addr/data
//   wrData/wrAddr/write : registered register-file write port
//   init_done : high in ARB;  grant_id : last accepted requester
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    localparam int IW = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [DW-1:0]      wrData,
    output logic [AW-1:0]      wrAddr,
    output logic               write,
    output logic               init_done,
    output logic [IW-1:0]      grant_id
);
    state_t state;
    logic [AW-1:0] cnt;
    logic [IW-1:0] rrPtr;
    logic [NREQ-1:0] pickGrant;
    logic [IW-1:0] pickIdx;
    logic accept;

    rr_priority_pick #(.NREQ(NREQ), .IW(IW)) picker (
        .req(req_valid),
        .ptr(rrPtr),
        .grant(pickGrant),
        .idx(pickIdx)
    );

    // A clear cycle in ARB grants nobody so no write is lost across the sweep.
    assign req_ready = (state == ARB && !clear) ? pickGrant : '0;
    assign accept = |(req_ready & req_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt <= '0;
            rrPtr <= '0;
            write <= 1'b0;
            wrAddr <= '0;
            wrData <= '0;
            init_done <= 1'b0;
            grant_id <= '0;
        end else if (state == INIT) begin
            write <= 1'b1;
            wrAddr <= cnt;
            wrData <= '0;
            cnt <= cnt + AW'(1);
            if (&cnt) begin
                state <= ARB;
                init_done <= 1'b1;
            end
        end else if (clear) begin
            state <= INIT;
            cnt <= '0;
            rrPtr <= '0;
            init_done <= 1'b0;
            write <= 1'b0;
        end else begin
            write <= accept;
            if (accept) begin
                wrAddr <= req_addr[pickIdx*AW +: AW];
                wrData <= req_data[pickIdx*DW +: DW];
                grant_id <= pickIdx;
                rrPtr <= (pickIdx == IW'(NREQ - 1)) ? '0 : pickIdx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: scoreboard bench for the register-file write arbiter
module tb_regfile_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int IW = 2;

    logic clk, reset, clear;
    logic [NREQ-1:0] req_valid, req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [DW-1:0] wrData;
    logic [AW-1:0] wrAddr;
    logic write, init_done;
    logic [IW-1:0] grant_id;

    regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_data(req_data),
        .wrData(wrData),
        .wrAddr(wrAddr),
        .write(write),
        .init_done(init_done),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int gid;
    } exp_t;

    exp_t sb[$];
    exp_t mon;
    int checks = 0;
    int errors = 0;
    int initLeft = 0;
    int expPtr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pushSweep();
        for (int a = 0; a < 2**AW; a++) sb.push_back('{addr: AW'(a), data: '0, gid: -1});
        initLeft = 2**AW;
        expPtr = 0;
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic setReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Drive one cycle: check combinational grant, predict the next-cycle write, advance.
    task automatic cycle(input logic [NREQ-1:0] v, input logic clr);
        logic [NREQ-1:0] expReady;
        logic nextWrite;
        logic inInit;
        int g;
        req_valid = v;
        clear = clr;
        #1;
        inInit = initLeft > 0;
        g = (inInit || clr) ? -1 : pick(v, expPtr);
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(expReady));
        check("init_done", 64'(init_done), 64'(!inInit));
        nextWrite = 1'b0;
        if (g >= 0) begin
            sb.push_back('{addr: req_addr[g*AW +: AW], data: req_data[g*DW +: DW], gid: g});
            expPtr = (g + 1) % NREQ;
            nextWrite = 1'b1;
        end else if (inInit) begin
            nextWrite = 1'b1;
            initLeft--;
        end else if (clr) begin
            pushSweep();
        end
        @(posedge clk);
        #1;
        check("write", 64'(write), 64'(nextWrite));
    endtask

    always @(negedge clk) begin
        if (reset && write) begin
            if (sb.size() == 0) check("spurious_write", 64'(write), 64'(0));
            else begin
                mon = sb.pop_front();
                check("wrAddr", 64'(wrAddr), 64'(mon.addr));
                check("wrData", 64'(wrData), 64'(mon.data));
                if (mon.gid >= 0) check("grant_id", 64'(grant_id), 64'(mon.gid));
            end
        end
    end

    task automatic checkCleared(input string tag);
        check({tag, "_write"}, 64'(write), 64'(0));
        check({tag, "_wrAddr"}, 64'(wrAddr), 64'(0));
        check({tag, "_wrData"}, 64'(wrData), 64'(0));
        check({tag, "_init_done"}, 64'(init_done), 64'(0));
        check({tag, "_grant_id"}, 64'(grant_id), 64'(0));
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        req_valid = '1;
        req_addr = '0;
        req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkCleared("reset");
        reset = 1'b1;
        req_valid = '0;
        pushSweep();
        repeat (32) cycle(4'b0000, 1'b0);
        // lone requester 2
        setReq(2, 5'h01, 32'habcd_efab);
        cycle(4'b0100, 1'b0);
        check("single_wrAddr", 64'(wrAddr), 64'h01);
        check("single_wrData", 64'(wrData), 64'habcd_efab);
        check("single_grant_id", 64'(grant_id), 64'd2);
        cycle(4'b0000, 1'b0);
        // requester 3 moves the pointer back to 0
        setReq(3, 5'h02, 32'h3333_3333);
        cycle(4'b1000, 1'b0);
        cycle(4'b0000, 1'b0);
        // all four contend: grants 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) setReq(i, AW'(4 + i), 32'h0123_4567 + DW'(i));
        repeat (5) cycle(4'b1111, 1'b0);
        cycle(4'b0000, 1'b0);
        // requester 1 streams back-to-back
        for (int n = 0; n < 4; n++) begin
            setReq(1, AW'(8 + n), 32'h1111_0000 + DW'(n));
            cycle(4'b0010, 1'b0);
        end
        setReq(0, 5'h0c, 32'h0000_00a0);
        setReq(1, 5'h0c, 32'h0000_00a1);
        cycle(4'b0011, 1'b0);
        check("rr_after_stream", 64'(grant_id), 64'd0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        // clear while requester 3 waits
        setReq(3, 5'h14, 32'hc3c3_c3c3);
        cycle(4'b1000, 1'b1);
        repeat (32) cycle(4'b1000, 1'b0);
        cycle(4'b1000, 1'b0);
        check("after_clear_grant_id", 64'(grant_id), 64'd3);
        cycle(4'b0000, 1'b0);
        // reset in the middle of a sweep
        cycle(4'b0000, 1'b1);
        repeat (18) cycle(4'b0000, 1'b0);
        check("sweep_addr_before_reset", 64'(wrAddr), 64'd17);
        reset = 1'b0;
        req_valid = '1;
        #1;
        checkCleared("midreset");
        sb.delete();
        initLeft = 0;
        @(posedge clk);
        #1;
        checkCleared("midreset_held");
        reset = 1'b1;
        req_valid = '0;
        pushSweep();
        repeat (32) cycle(4'b0000, 1'b0);
        setReq(0, 5'h00, 32'hfeed_0000);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
